// File: rtl/img1bit_pkg.sv
// ============================================================================
// Module : img1bit_pkg
// Brief  : Mode encoding, stage-select types and mode decode shared by the
//          1-bit morphology control logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package img1bit_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_BYPASS = 3'd0;
  localparam mode_t MODE_ERODE  = 3'd1;
  localparam mode_t MODE_DILATE = 3'd2;
  localparam mode_t MODE_OPEN   = 3'd3;
  localparam mode_t MODE_CLOSE  = 3'd4;

  typedef struct packed {
    logic dilate;
    logic bypass;
  } stage_sel_t;

  typedef struct packed {
    stage_sel_t s1;
    stage_sel_t s2;
  } morph_sel_t;

  function automatic logic is_legal_mode(input mode_t m);
    return (m <= MODE_CLOSE);
  endfunction

  // Illegal codes fall back to full bypass; they never reach the commit path.
  function automatic morph_sel_t decode_mode(input mode_t m);
    morph_sel_t s;
    s.s1.dilate = 1'b0;
    s.s1.bypass = 1'b1;
    s.s2.dilate = 1'b0;
    s.s2.bypass = 1'b1;
    case (m)
      MODE_ERODE: begin
        s.s1.bypass = 1'b0;
      end
      MODE_DILATE: begin
        s.s1.dilate = 1'b1;
        s.s1.bypass = 1'b0;
      end
      MODE_OPEN: begin
        s.s1.bypass = 1'b0;
        s.s2.dilate = 1'b1;
        s.s2.bypass = 1'b0;
      end
      MODE_CLOSE: begin
        s.s1.dilate = 1'b1;
        s.s1.bypass = 1'b0;
        s.s2.bypass = 1'b0;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_sync_edge.sv
// ============================================================================
// Module : img_sync_edge
// Brief  : Registers frame/line syncs and produces vsync-rise and href-fall
//          single-cycle pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module img_sync_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pre_vsync,
  input  logic pre_href,
  output logic vs_rise,
  output logic href_fall
);

  logic r_vsync_d;
  logic r_href_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= pre_vsync;
      r_href_d  <= pre_href;
    end
  end

  assign vs_rise   = pre_vsync & ~r_vsync_d;
  assign href_fall = ~pre_href & r_href_d;

endmodule

`default_nettype wire

// File: rtl/img1bit_morph_ctrl.sv
// ============================================================================
// Module : img1bit_morph_ctrl
// Brief  : Frame-synchronous mode controller for the two-stage 1-bit
//          morphology chain; optional frame-geometry check via
//          MORPH_GEOM_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module img1bit_morph_ctrl
  import img1bit_pkg::*;
#(
  parameter int         IMG_W    = 640,
  parameter int         IMG_H    = 480,
  parameter logic [2:0] RST_MODE = 3'd0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pre_vsync,
  input  logic        pre_href,
  input  logic        wr_en,
  input  logic [2:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  output logic        mode_err,
  output logic [2:0]  cur_mode,
  output logic        s1_dilate,
  output logic        s1_bypass,
  output logic        s2_dilate,
  output logic        s2_bypass,
  output logic [15:0] frame_cnt,
  output logic        geom_err
);

  localparam logic [0:0] c_st_sync   = 1'b0;
  localparam logic [0:0] c_st_active = 1'b1;
  localparam morph_sel_t c_rst_sel   = decode_mode(RST_MODE);

  logic [0:0] r_state;
  logic       r_pend_full;
  mode_t      r_pend_mode;
  logic       r_mode_err;
  mode_t      r_cur_mode;
  morph_sel_t r_sel;
  logic [15:0] r_frame_cnt;

  logic w_vs_rise;
  logic w_href_fall;
  logic w_accept;
  logic w_legal;

  img_sync_edge u_sync_edge (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pre_vsync (pre_vsync),
    .pre_href  (pre_href),
    .vs_rise   (w_vs_rise),
    .href_fall (w_href_fall)
  );

  assign w_accept = mode_req_valid & ~r_pend_full;
  assign w_legal  = is_legal_mode(mode_req);

  // The pending slot is only consulted at vs_rise, so a request accepted on
  // that same cycle waits for the following frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= c_st_sync;
      r_pend_full <= 1'b0;
      r_pend_mode <= MODE_BYPASS;
      r_mode_err  <= 1'b0;
      r_cur_mode  <= RST_MODE;
      r_sel       <= c_rst_sel;
      r_frame_cnt <= 16'd0;
    end else begin
      r_mode_err <= w_accept & ~w_legal;

      if (w_vs_rise && r_pend_full) begin
        r_pend_full <= 1'b0;
        r_cur_mode  <= r_pend_mode;
        r_sel       <= decode_mode(r_pend_mode);
      end else if (w_accept && w_legal) begin
        r_pend_full <= 1'b1;
        r_pend_mode <= mode_req;
      end

      case (r_state)
        c_st_sync: begin
          if (w_vs_rise) r_state <= c_st_active;
        end
        c_st_active: begin
          if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        default: r_state <= c_st_sync;
      endcase
    end
  end

`ifdef MORPH_GEOM_CHECK_EN
  logic [11:0] r_pix_cnt;
  logic [11:0] r_line_cnt;
  logic        r_width_bad;
  logic        r_geom_err;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pix_cnt   <= 12'd0;
      r_line_cnt  <= 12'd0;
      r_width_bad <= 1'b0;
      r_geom_err  <= 1'b0;
    end else begin
      r_geom_err <= 1'b0;
      if (w_vs_rise) begin
        // A frame entered from SYNC may be partial, so it is never judged.
        if (r_state == c_st_active)
          r_geom_err <= r_width_bad | (r_line_cnt != 12'(IMG_H));
        r_pix_cnt   <= 12'd0;
        r_line_cnt  <= 12'd0;
        r_width_bad <= 1'b0;
      end else if (w_href_fall) begin
        if (r_line_cnt != 12'hFFF) r_line_cnt <= r_line_cnt + 12'd1;
        if (r_pix_cnt != 12'(IMG_W)) r_width_bad <= 1'b1;
        r_pix_cnt <= 12'd0;
      end else if (wr_en && pre_href && (r_pix_cnt != 12'hFFF)) begin
        r_pix_cnt <= r_pix_cnt + 12'd1;
      end
    end
  end

  assign geom_err = r_geom_err;
`else
  logic w_unused_geom;
  assign w_unused_geom = ^{pre_href, wr_en, w_href_fall, 12'(IMG_W), 12'(IMG_H)};
  assign geom_err      = 1'b0;
`endif

  assign mode_req_ready = ~r_pend_full;
  assign mode_err       = r_mode_err;
  assign cur_mode       = r_cur_mode;
  assign s1_dilate      = r_sel.s1.dilate;
  assign s1_bypass      = r_sel.s1.bypass;
  assign s2_dilate      = r_sel.s2.dilate;
  assign s2_bypass      = r_sel.s2.bypass;
  assign frame_cnt      = r_frame_cnt;

endmodule

`default_nettype wire

// File: doc/img1bit_morph_ctrl.md
Name: img1bit_morph_ctrl

Overview:
- Frame-synchronous mode controller for the 1-bit morphology chain: two cascaded 3x3 stages, each configurable as erode, dilate or bypass.
- Accepts mode-change requests from the mode-switch logic (keys/UART) through a valid/ready handshake, holds them pending, and commits them only at frame start, so no frame is processed with mixed settings.
- Tracks frame count and, optionally, checks incoming frame geometry against the configured size.

Parameters:
- IMG_W, 640, active pixels per line (wr_en pulses per href).
- IMG_H, 480, active lines per frame.
- RST_MODE, 3'd0, mode committed at reset.

Ports:
- sys_clk  in  1  pixel clock.
- sys_rst  in  1  reset.
- pre_vsync  in  1  frame sync, active-high; rising edge = frame start.
- pre_href  in  1  line valid, active-high.
- wr_en  in  1  pixel valid.
- mode_req  in  3  requested mode.
- mode_req_valid  in  1  request strobe.
- mode_req_ready  out  1  pending slot free.
- mode_err  out  1  one-cycle pulse: illegal mode rejected.
- cur_mode  out  3  committed mode.
- s1_dilate  out  1  stage 1 op: 0 = erode, 1 = dilate.
- s1_bypass  out  1  stage 1 passes pixel unchanged.
- s2_dilate  out  1  stage 2 op: 0 = erode, 1 = dilate.
- s2_bypass  out  1  stage 2 passes pixel unchanged.
- frame_cnt  out  16  completed frames, wraps.
- geom_err  out  1  one-cycle pulse at frame start if the previous frame size was wrong.

Behaviour:
- One clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values:
  - cur_mode = RST_MODE; stage selects decoded from RST_MODE.
  - mode_req_ready = 1; mode_err = 0; frame_cnt = 0; geom_err = 0.
  - Pending slot empty; FSM in SYNC.
- Mode encoding and decode:
  - 0 BYPASS: s1 bypass, s2 bypass.
  - 1 ERODE: s1 erode, s2 bypass.
  - 2 DILATE: s1 dilate, s2 bypass.
  - 3 OPEN: s1 erode, s2 dilate.
  - 4 CLOSE: s1 dilate, s2 erode.
  - 5-7 illegal.
  - Decoded outputs are registered.
- Edge detect: vs_rise = pre_vsync & ~vsync_d, where vsync_d is pre_vsync registered. href_fall is derived the same way.
- Handshake:
  - A request is accepted when mode_req_valid & mode_req_ready.
  - Legal mode: stored in the pending slot; mode_req_ready drops the next cycle.
  - Illegal mode: mode_err pulses the next cycle; pending slot unchanged; ready unchanged.
  - mode_req_valid while ready = 0 is ignored; the requester must hold it.
- FSM:
  - SYNC: outputs hold the current decode. On vs_rise, commit the pending slot if full, then go to ACTIVE. frame_cnt is not incremented on this first edge.
  - ACTIVE, on each vs_rise:
    - frame_cnt += 1.
    - If pending is full: cur_mode and stage selects update on the next edge (1-cycle latency from the vs_rise cycle); pending cleared; ready = 1 the following cycle.
    - If pending is empty: settings are unchanged.
- Simultaneous events: an accepted request in the same cycle as vs_rise is not committed this frame. It lands in the slot and commits at the next vs_rise. A request already pending is committed at that vs_rise, and the new one is refused because ready is 0.
- Consecutive requests: only one pending; the latest accepted request wins at commit.
- Reset mid-frame: everything returns to reset values and SYNC. The remainder of the current frame runs with the RST_MODE decode. No geom_err is reported for that frame.
- frame_cnt wraps 16'hFFFF -> 0.

Optional Feature:
- Macro MORPH_GEOM_CHECK_EN.
- Defined:
  - A pixel counter counts wr_en & pre_href and clears on href_fall.
  - On href_fall, the line counter increments; a per-frame width_bad flag is set if the pixel count != IMG_W.
  - On vs_rise in ACTIVE, geom_err pulses for one cycle if width_bad is set or the line count != IMG_H. Counters and the flag then clear.
  - Counters saturate at 12 bits.
- Undefined: geom_err is tied to 0 and no counters are synthesized.

Decomposition:
- Shared package img1bit_pkg:
  - Mode constants MODE_BYPASS .. MODE_CLOSE.
  - 3-bit mode typedef.
  - Stage-select struct {dilate, bypass}.
  - Decode function mode -> two stage structs.
- Sub-module img_sync_edge: registers vsync/href and outputs rise/fall pulses. It is reused by the geometry checker.

Test Plan:
- Reset with RST_MODE = 0, then request mode 3 mid-frame -> ready drops 1 cycle later. At the next vs_rise, cur_mode = 3, s1 = erode, s2 = dilate (1 cycle after the rise cycle); ready returns to 1.
- Request mode 6 -> mode_err is a single-cycle pulse; cur_mode and ready unchanged.
- Request mode 4 exactly on a vs_rise cycle with the slot empty -> the mode is unchanged for that frame and commits at the following vs_rise. frame_cnt increments by 2 over the two edges.
- Request 2 accepted; request 1 presented while ready = 0 -> the second request is ignored and cur_mode becomes 2.
- With MORPH_GEOM_CHECK_EN, IMG_W = 8, IMG_H = 4:
  - Frame of 4 lines x 8 pixels -> no geom_err.
  - Frame with line 2 of 7 pixels -> geom_err pulse at the next vs_rise.
  - Frame of 3 lines -> geom_err pulse.
- Assert sys_rst for 1 cycle mid-frame with a pending request -> pending is lost, cur_mode = RST_MODE, frame_cnt = 0, and the FSM resyncs on the next vs_rise without a geom_err pulse.
